fc2_argmax: RTL and testbench

Second fully-connected layer and classifier head of the quickdraw CNN. It consumes the 128 ReLU'd 32-bit activations produced by fc1 and computes NUM_CLASSES signed class scores as bias + Σ input×int8 weight, with no activation. It tracks the running maximum to report the predicted class. Control uses the same start/done level handshake as the other layer stages, so it chains directly after fc1's done.

---
 rtl/qd_pkg.sv | 20 ++
 rtl/argmax_tracker.sv | 30 +++
 rtl/fc2_argmax.sv | 118 +++++++++++
 tb/tb_fc2_argmax.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/qd_pkg.sv
// Shared constants and the fc2 state type for the quickdraw CNN layer stages.
package qd_pkg;

  localparam int FC1_OUT     = 128;
  localparam int NUM_CLASSES = 10;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;

  typedef enum logic [2:0] {
    IDLE,
    INIT_CLASS,
    MAC,
    STORE,
    NEXT_CLASS,
    DONE,
    WAIT_START_LOW
  } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running maximum of resolved class scores; strict-greater update so ties keep the lower index.
module argmax_tracker
  import qd_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               valid,
  input  logic signed [31:0] score,
  input  logic [CW-1:0]      idx,
  output logic signed [31:0] best_score,
  output logic [CW-1:0]      best_idx
);

  always_ff @(posedge clk) begin
    if (reset) begin
      best_score <= '0;
      best_idx   <= '0;
    end else if (clear) begin
      best_score <= INT32_MIN;
      best_idx   <= '0;
    end else if (valid && (score > best_score)) begin
      best_score <= score;
      best_idx   <= idx;
    end
  end

endmodule

// File: rtl/fc2_argmax.sv
// fc2 layer + argmax head: one MAC per cycle over NUM_IN inputs per class.
// Define FC2_SAT_EN to saturate scores to int32; otherwise scores wrap to acc[31:0].
module fc2_argmax
  import qd_pkg::*;
#(
  parameter int NUM_IN      = qd_pkg::FC1_OUT,
  parameter int NUM_CLASSES = qd_pkg::NUM_CLASSES,
  localparam int CW         = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  input  logic signed [31:0] fc1_output [0:NUM_IN-1],
  input  logic signed [7:0]  weights    [0:NUM_CLASSES-1][0:NUM_IN-1],
  input  logic signed [31:0] biases     [0:NUM_CLASSES-1],
  output logic signed [31:0] scores     [0:NUM_CLASSES-1],
  output logic [CW-1:0]      pred_class,
  output logic signed [31:0] pred_score
);

  localparam int IW = $clog2(NUM_IN);
  localparam logic [IW-1:0] LAST_IN    = IW'(NUM_IN - 1);
  localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);

  state_t state, next_state;

  logic [CW-1:0]      class_idx;
  logic [IW-1:0]      input_idx;
  logic signed [47:0] acc;
  logic signed [39:0] prod;
  logic signed [31:0] score;
  logic signed [31:0] best_score;
  logic [CW-1:0]      best_idx;
  logic               accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:           if (start) next_state = INIT_CLASS;
      INIT_CLASS:     next_state = MAC;
      MAC:            if (input_idx == LAST_IN) next_state = STORE;
      STORE:          next_state = NEXT_CLASS;
      NEXT_CLASS:     next_state = (class_idx == LAST_CLASS) ? DONE : INIT_CLASS;
      DONE:           next_state = WAIT_START_LOW;
      WAIT_START_LOW: if (!start) next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end

  always_comb begin
    prod = 40'(fc1_output[input_idx]) * 40'(weights[class_idx][input_idx]);
  end

  always_comb begin
`ifdef FC2_SAT_EN
    if (acc > 48'(INT32_MAX))      score = INT32_MAX;
    else if (acc < 48'(INT32_MIN)) score = INT32_MIN;
    else                           score = acc[31:0];
`else
    score = acc[31:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      class_idx  <= '0;
      input_idx  <= '0;
      acc        <= '0;
      pred_class <= '0;
      pred_score <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) scores[c] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          done      <= 1'b0;
          class_idx <= '0;
        end
        INIT_CLASS: begin
          acc       <= 48'(biases[class_idx]);
          input_idx <= '0;
        end
        MAC: begin
          acc <= acc + 48'(prod);
          if (input_idx != LAST_IN) input_idx <= input_idx + 1'b1;
        end
        STORE:      scores[class_idx] <= score;
        NEXT_CLASS: if (class_idx != LAST_CLASS) class_idx <= class_idx + 1'b1;
        DONE: begin
          pred_class <= best_idx;
          pred_score <= best_score;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  argmax_tracker #(.CW(CW)) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .valid      (state == STORE),
    .score      (score),
    .idx        (class_idx),
    .best_score (best_score),
    .best_idx   (best_idx)
  );

endmodule

// File: tb/tb_fc2_argmax.sv
// Scoreboard bench for fc2_argmax: directed and random runs against a longint reference model.
module tb_fc2_argmax;

  localparam int NI = 128;
  localparam int NC = 10;
  localparam int LAT = NC * (NI + 3) + 1;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;
  logic signed [31:0] fc1 [0:NI-1];
  logic signed [7:0]  w   [0:NC-1][0:NI-1];
  logic signed [31:0] b   [0:NC-1];
  logic signed [31:0] scores [0:NC-1];
  logic [3:0]         pred_class;
  logic signed [31:0] pred_score;

  fc2_argmax #(.NUM_IN(NI), .NUM_CLASSES(NC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .fc1_output (fc1),
    .weights    (w),
    .biases     (b),
    .scores     (scores),
    .pred_class (pred_class),
    .pred_score (pred_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0][31:0] sc;
    logic [3:0]          cls;
    logic [31:0]         ps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Reference: exact dot product in 64 bits, then resolve, then first index holding the max.
  task automatic model_push();
    exp_t e;
    longint sum;
    logic signed [31:0] r [0:NC-1];
    logic signed [31:0] mx;
    int first;
    for (int c = 0; c < NC; c++) begin
      sum = longint'(b[c]);
      for (int i = 0; i < NI; i++) sum += longint'(fc1[i]) * longint'(w[c][i]);
`ifdef FC2_SAT_EN
      if (sum > 64'sd2147483647)       r[c] = 32'sh7fff_ffff;
      else if (sum < -64'sd2147483648) r[c] = 32'sh8000_0000;
      else                             r[c] = sum[31:0];
`else
      r[c] = sum[31:0];
`endif
      e.sc[c] = r[c];
    end
    mx = r[0];
    for (int c = 1; c < NC; c++) if (r[c] > mx) mx = r[c];
    first = -1;
    for (int c = NC - 1; c >= 0; c--) if (r[c] == mx) first = c;
    e.cls = 4'(first);
    e.ps  = mx;
    q.push_back(e);
  endtask

  // Monitor: every rising done pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done && !prev_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
      end else begin
        e = q.pop_front();
        for (int c = 0; c < NC; c++) chk($sformatf("scores[%0d]", c), scores[c], e.sc[c]);
        chk("pred_class", 32'(pred_class), 32'(e.cls));
        chk("pred_score", pred_score, e.ps);
        chk("latency", 32'(cyc - accept_cyc), 32'(LAT));
      end
    end
    prev_done = done;
  end

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 accept_cyc = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic run_full();
    model_push();
    start_run();
    wait_done();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pred_class"}, 32'(pred_class), 32'd0);
    chk({tag, "_pred_score"}, pred_score, 32'd0);
    for (int c = 0; c < NC; c++) chk($sformatf("%s_scores[%0d]", tag, c), scores[c], 32'd0);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) fc1[i] = '0;
    for (int c = 0; c < NC; c++) begin
      b[c] = '0;
      for (int i = 0; i < NI; i++) w[c][i] = '0;
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NI; i++) fc1[i] = 32'($urandom_range(0, 32'h7fff_ffff));
    for (int c = 0; c < NC; c++) begin
      b[c] = 32'($urandom);
      for (int i = 0; i < NI; i++) w[c][i] = 8'($urandom);
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    start = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    clear_inputs();
    for (int c = 0; c < NC; c++) b[c] = 32'(10 * c);
    run_full();

    clear_inputs();
    for (int i = 0; i < NI; i++) begin
      fc1[i] = 32'sd1;
      w[3][i] = 8'sd1;
    end
    run_full();

    clear_inputs();
    for (int c = 0; c < NC; c++) b[c] = 32'sd5;
    run_full();

    clear_inputs();
    for (int c = 0; c < NC; c++) b[c] = 32'(-100 + c);
    run_full();

    clear_inputs();
    for (int i = 0; i < NI; i++) begin
      fc1[i] = 32'sh7fff_ffff;
      w[0][i] = 8'sd127;
    end
    run_full();

    repeat (3) begin
      randomize_inputs();
      run_full();
    end

    // Abort in the MAC phase of class 4; no result is expected from this run.
    randomize_inputs();
    start_run();
    repeat (600) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun");
    reset = 1'b0;
    prev_done = done;
    randomize_inputs();
    run_full();

    // Start held high after done must not retrigger.
    randomize_inputs();
    model_push();
    start_run();
    wait_done();
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!done) bad++;
    end
    chk("held_start_done_low_cycles", 32'(bad), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    randomize_inputs();
    run_full();

    repeat (5) @(negedge clk);
    chk("pending_results", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
